// File: rtl/flash_qspi_read_ctrl_if.sv
// Request/response bundle between the flash requester and the QSPI read controller.
// Ports: req_valid/req_ready/req_addr/req_len request, rdata/rdata_valid response, busy status.
interface flash_qspi_read_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [7:0]  req_len;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;

    modport master (
        output req_valid, req_addr, req_len,
        input  req_ready, rdata, rdata_valid, busy
    );

    modport slave (
        input  req_valid, req_addr, req_len,
        output req_ready, rdata, rdata_valid, busy
    );
endinterface

// File: rtl/flash_qspi_read_ctrl.sv
// Quad-I/O fast read (0xEB) sequencer driving registered-IO flash pads in the clk_2x domain.
// Ports: clk, reset (sync, active-high), bus (slave request/response bundle),
//   flash_clk_ddr (SCK pattern), flash_csn, flash_in_en / flash_in (outbound lanes),
//   flash_out (inbound nibble).
// Optional: define FLASH_QSPI_CRM_EN for continuous read mode (mode 0xA0, CMD skipped
//   after the first read, CRM exit sequence after reset).
module flash_qspi_read_ctrl #(
    parameter int unsigned DUMMY_CYCLES    = 4,
    parameter int unsigned READ_LATENCY    = 2,
    parameter int unsigned CSN_HIGH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    flash_qspi_read_ctrl_if.slave        bus,
    output logic [1:0]                   flash_clk_ddr,
    output logic                         flash_csn,
    output logic [3:0]                   flash_in_en,
    output logic [3:0]                   flash_in,
    input  logic [3:0]                   flash_out
);

    localparam logic [7:0] CMD_BYTE = 8'hEB;
`ifdef FLASH_QSPI_CRM_EN
    localparam logic [7:0] MODE_BYTE = 8'hA0;
`else
    localparam logic [7:0] MODE_BYTE = 8'h00;
`endif
    localparam logic [7:0] GAP_INIT = 8'(CSN_HIGH_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_DRAIN,
        S_DESEL
`ifdef FLASH_QSPI_CRM_EN
        , S_CRM_EXIT
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [10:0]             cnt_q, cnt_d;
    logic [7:0]              gap_q, gap_d;
    logic [23:0]             addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic                    csn_q, csn_d;
    logic [1:0]              ddr_q, ddr_d;
    logic [3:0]              in_en_q, in_en_d;
    logic [3:0]              in_q, in_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [2:0]              cap_cnt_q, cap_cnt_d;
    logic [31:0]             word_q, word_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
`ifdef FLASH_QSPI_CRM_EN
    logic                    crm_q, crm_d;
`endif

    logic        accept;
    logic [10:0] last;
    logic        at_last;
    logic [23:0] addr_sh;
    logic        cap;
    logic [4:0]  nib_idx;
    logic [31:0] word_ins;

    assign accept = bus.req_valid && ready_q;

    // Phase length minus one for the current state.
    always_comb begin
        last = '0;
        unique case (state_q)
            S_CMD:      last = 11'd7;
            S_ADDR:     last = 11'd5;
            S_MODE:     last = 11'd1;
            S_DUMMY:    last = 11'(DUMMY_CYCLES - 1);
            S_DATA:     last = {len_q, 3'b111};
            S_DRAIN:    last = 11'(READ_LATENCY - 1);
            S_DESEL:    last = 11'(CSN_HIGH_CYCLES - 1);
`ifdef FLASH_QSPI_CRM_EN
            S_CRM_EXIT: last = 11'd7;
`endif
            default:    last = '0;
        endcase
    end

    assign at_last = (cnt_q == last);

    // Next state. gap_q counts csn-high cycles still owed after a reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        addr_d  = addr_q;
        len_d   = len_q;
        busy_d  = busy_q;
`ifdef FLASH_QSPI_CRM_EN
        crm_d   = crm_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
                if (accept) begin
                    addr_d = bus.req_addr;
                    len_d  = bus.req_len;
                    busy_d = 1'b1;
                    cnt_d  = '0;
`ifdef FLASH_QSPI_CRM_EN
                    state_d = crm_q ? S_ADDR : S_CMD;
`else
                    state_d = S_CMD;
`endif
                end
            end
`ifdef FLASH_QSPI_CRM_EN
            S_CRM_EXIT: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (at_last) begin
                    cnt_d   = '0;
                    state_d = S_DESEL;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
`endif
            S_DESEL: begin
                if (at_last) begin
                    cnt_d   = '0;
                    gap_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: begin
                if (at_last) begin
                    cnt_d = '0;
                    unique case (state_q)
                        S_CMD:   state_d = S_ADDR;
                        S_ADDR:  state_d = S_MODE;
                        S_MODE:  state_d = S_DUMMY;
                        S_DUMMY: state_d = S_DATA;
                        S_DATA:  state_d = S_DRAIN;
                        default: begin
                            state_d = S_DESEL;
`ifdef FLASH_QSPI_CRM_EN
                            crm_d = 1'b1;
`endif
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
        endcase
    end

    // Pad outputs are decoded from the next state so they line up with state_q.
    assign addr_sh = addr_d << {cnt_d[2:0], 2'b00};

    always_comb begin
        csn_d   = 1'b1;
        ddr_d   = 2'b00;
        in_en_d = 4'b0000;
        in_d    = 4'b0000;
        ready_d = (state_d == S_IDLE) && (gap_d <= 8'd1);
        unique case (state_d)
            S_CMD: begin
                csn_d   = 1'b0;
                ddr_d   = 2'b01;
                in_en_d = 4'b0001;
                in_d    = {3'b000, CMD_BYTE[3'd7 - cnt_d[2:0]]};
            end
            S_ADDR: begin
                csn_d   = 1'b0;
                ddr_d   = 2'b01;
                in_en_d = 4'b1111;
                in_d    = addr_sh[23:20];
            end
            S_MODE: begin
                csn_d   = 1'b0;
                ddr_d   = 2'b01;
                in_en_d = 4'b1111;
                in_d    = cnt_d[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
            end
            S_DUMMY, S_DATA: begin
                csn_d = 1'b0;
                ddr_d = 2'b01;
            end
            S_DRAIN: begin
                csn_d = 1'b0;
            end
`ifdef FLASH_QSPI_CRM_EN
            S_CRM_EXIT: begin
                if (gap_d == 8'd0) begin
                    csn_d   = 1'b0;
                    ddr_d   = 2'b01;
                    in_en_d = 4'b1111;
                    in_d    = 4'b1111;
                end
            end
`endif
            default: begin
                csn_d = 1'b1;
            end
        endcase
    end

    // Capture side trails the data SCK pulses by READ_LATENCY cycles.
    assign cap      = pipe_q[READ_LATENCY-1];
    assign nib_idx  = {cap_cnt_q[2:1], ~cap_cnt_q[0], 2'b00};

    always_comb begin
        pipe_d            = (pipe_q << 1) | READ_LATENCY'(state_q == S_DATA);
        word_ins          = word_q;
        word_ins[nib_idx +: 4] = flash_out;
        word_d            = cap ? word_ins : word_q;
        cap_cnt_d         = cap ? cap_cnt_q + 3'd1 : cap_cnt_q;
        rvalid_d          = cap && (cap_cnt_q == 3'd7);
        rdata_d           = rvalid_d ? word_ins : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef FLASH_QSPI_CRM_EN
            state_q <= S_CRM_EXIT;
            crm_q   <= 1'b0;
`else
            state_q <= S_IDLE;
`endif
            cnt_q     <= '0;
            gap_q     <= GAP_INIT;
            addr_q    <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            csn_q     <= 1'b1;
            ddr_q     <= 2'b00;
            in_en_q   <= 4'b0000;
            in_q      <= 4'b0000;
            pipe_q    <= '0;
            cap_cnt_q <= '0;
            word_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
`ifdef FLASH_QSPI_CRM_EN
            crm_q     <= crm_d;
`endif
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            csn_q     <= csn_d;
            ddr_q     <= ddr_d;
            in_en_q   <= in_en_d;
            in_q      <= in_d;
            pipe_q    <= pipe_d;
            cap_cnt_q <= cap_cnt_d;
            word_q    <= word_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.busy        = busy_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
    assign flash_csn       = csn_q;
    assign flash_clk_ddr   = ddr_q;
    assign flash_in_en     = in_en_q;
    assign flash_in        = in_q;

endmodule

// File: tb/tb_flash_qspi_read_ctrl.sv
// Directed bench for flash_qspi_read_ctrl with a behavioural quad-I/O flash model.
// Model decodes cmd/addr/mode from the pads and returns data READ_LATENCY cycles later.
module tb_flash_qspi_read_ctrl;
    localparam int DUMMY = 4;
    localparam int RL    = 2;
    localparam int CSNH  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] flash_clk_ddr;
    logic       flash_csn;
    logic [3:0] flash_in_en;
    logic [3:0] flash_in;
    logic [3:0] flash_out = 4'h0;

    flash_qspi_read_ctrl_if bus();

    flash_qspi_read_ctrl #(
        .DUMMY_CYCLES    (DUMMY),
        .READ_LATENCY    (RL),
        .CSN_HIGH_CYCLES (CSNH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .flash_clk_ddr (flash_clk_ddr),
        .flash_csn     (flash_csn),
        .flash_in_en   (flash_in_en),
        .flash_in      (flash_in),
        .flash_out     (flash_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and response monitor.
    int          cyc = 0;
    int          acc_n = 0;
    int          acc_cyc[$];
    logic [31:0] rq[$];
    int          rc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready && !reset) begin
            acc_n++;
            acc_cyc.push_back(cyc);
        end
        if (bus.rdata_valid) begin
            rq.push_back(bus.rdata);
            rc.push_back(cyc);
        end
    end

    // Flash model.
    int          pat = 0;
    int          pc = 0;
    int          dpc = 0;
    int          oe_bad = 0;
    int          sck_hi = 0;
    int          hi_run = 0;
    int          min_gap = 1000;
    bit          seen_low = 0;
    logic [7:0]  m_cmd = 8'h0;
    logic [7:0]  m_mode = 8'h0;
    logic [23:0] m_addr = 24'h0;
    logic [3:0]  d0 = 4'h0;
    logic [3:0]  d1 = 4'h0;

    function automatic logic [7:0] byte_at(input int o);
        logic [23:0] t;
        logic [7:0]  b;
        t = m_addr + 24'(o);
        b = (pat == 0) ? 8'(8'h11 * (o + 1)) : t[7:0];
        return b;
    endfunction

    always @(negedge clk) begin
        logic [3:0] nib;
        logic [7:0] b;
        int n;
        nib = 4'h0;
        flash_out = d1;
        d1 = d0;
        if (flash_csn === 1'b1) begin
            pc = 0;
            hi_run++;
            if (flash_clk_ddr != 2'b00) sck_hi++;
        end else if (flash_csn === 1'b0) begin
            if (hi_run > 0 && seen_low && hi_run < min_gap) min_gap = hi_run;
            if (hi_run > 0) dpc = 0;
            seen_low = 1;
            hi_run = 0;
            if (flash_clk_ddr == 2'b01) begin
                if (pc < 8) begin
                    m_cmd = {m_cmd[6:0], flash_in[0]};
                    if (flash_in_en != 4'b0001) oe_bad++;
                end else if (pc < 14) begin
                    m_addr = {m_addr[19:0], flash_in};
                    if (flash_in_en != 4'b1111) oe_bad++;
                end else if (pc < 16) begin
                    m_mode = {m_mode[3:0], flash_in};
                    if (flash_in_en != 4'b1111) oe_bad++;
                end else begin
                    if (flash_in_en != 4'b0000) oe_bad++;
                    if (pc >= 16 + DUMMY) begin
                        n = pc - 16 - DUMMY;
                        b = byte_at(n / 2);
                        nib = (n % 2 == 0) ? b[7:4] : b[3:0];
                        dpc++;
                    end
                end
                pc++;
            end
        end
        d0 = nib;
    end

    function automatic logic [31:0] exp_word(input logic [23:0] a, input int w);
        logic [31:0] r;
        logic [23:0] t;
        for (int j = 0; j < 4; j++) begin
            t = a + 24'(4 * w + j);
            r[8*j +: 8] = t[7:0];
        end
        return r;
    endfunction

    task automatic send(input logic [23:0] a, input logic [7:0] l, input bit hold);
        int k;
        k = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        while (!bus.req_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (rq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_ready(input int budget);
        int k;
        k = 0;
        while (!bus.req_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("ready_return", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int a1;
        int a2;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        repeat (3) @(negedge clk);

        chk("rst_csn", 32'(flash_csn), 32'd1);
        chk("rst_ddr", 32'(flash_clk_ddr), 32'd0);
        chk("rst_in_en", 32'(flash_in_en), 32'd0);
        chk("rst_in", 32'(flash_in), 32'd0);
        chk("rst_rvalid", 32'(bus.rdata_valid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        // Single word.
        pat = 0;
        rq.delete();
        rc.delete();
        send(24'h123456, 8'd0, 1'b0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        wait_words(1, 100);
        wait_ready(100);
        chk("t1_cmd", 32'(m_cmd), 32'hEB);
        chk("t1_addr", 32'(m_addr), 32'h123456);
        chk("t1_mode", 32'(m_mode), 32'h00);
        chk("t1_count", rq.size(), 32'd1);
        if (rq.size() >= 1) begin
            chk("t1_data", rq[0], 32'h44332211);
            chk("t1_latency", 32'(rc[0] - acc_cyc[acc_cyc.size()-1]), 32'd31);
        end
        chk("t1_csn_after", 32'(flash_csn), 32'd1);

        // Burst of 4.
        pat = 1;
        rq.delete();
        rc.delete();
        send(24'h000100, 8'd3, 1'b0);
        wait_words(4, 200);
        wait_ready(100);
        chk("t2_count", rq.size(), 32'd4);
        if (rq.size() == 4) begin
            chk("t2_w0", rq[0], 32'h03020100);
            chk("t2_w1", rq[1], 32'h07060504);
            chk("t2_w2", rq[2], 32'h0B0A0908);
            chk("t2_w3", rq[3], 32'h0F0E0D0C);
            for (int i = 0; i < 3; i++)
                chk("t2_spacing", 32'(rc[i+1] - rc[i]), 32'd8);
        end

        // Back-to-back with req_valid held.
        rq.delete();
        rc.delete();
        a1 = acc_n;
        send(24'h000200, 8'd0, 1'b1);
        bus.req_addr = 24'h000300;
        chk("t3_ready_low", 32'(bus.req_ready), 32'd0);
        wait_ready(100);
        chk("t3_busy_at_ready", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_words(2, 100);
        wait_ready(100);
        repeat (20) @(negedge clk);
        chk("t3_accepts", 32'(acc_n - a1), 32'd2);
        if (acc_n - a1 == 2) begin
            a2 = acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2];
            chk("t3_accept_gap", 32'(a2), 32'd33);
        end
        chk("t3_count", rq.size(), 32'd2);
        if (rq.size() == 2) begin
            chk("t3_w0", rq[0], exp_word(24'h000200, 0));
            chk("t3_w1", rq[1], exp_word(24'h000300, 0));
        end

        // Reset in the middle of an 8-word burst.
        rq.delete();
        rc.delete();
        send(24'h000400, 8'd7, 1'b0);
        wait_words(3, 200);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_csn", 32'(flash_csn), 32'd1);
        chk("t4_ddr", 32'(flash_clk_ddr), 32'd0);
        chk("t4_in_en", 32'(flash_in_en), 32'd0);
        chk("t4_rvalid", 32'(bus.rdata_valid), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4_count", rq.size(), 32'd3);
        if (rq.size() == 3) begin
            for (int i = 0; i < 3; i++)
                chk("t4_word", rq[i], exp_word(24'h000400, i));
        end
        rq.delete();
        rc.delete();
        send(24'h000500, 8'd1, 1'b0);
        wait_words(2, 200);
        wait_ready(100);
        chk("t4_after_count", rq.size(), 32'd2);
        if (rq.size() == 2) begin
            chk("t4_after_w0", rq[0], 32'h03020100 + 32'h0);
            chk("t4_after_w1", rq[1], 32'h07060504);
        end

        // Max length burst.
        rq.delete();
        rc.delete();
        send(24'h00FF00, 8'd255, 1'b0);
        wait_words(256, 2300);
        wait_ready(100);
        chk("t5_count", rq.size(), 32'd256);
        chk("t5_sck_data", dpc, 32'd2048);
        if (rq.size() == 256) begin
            chk("t5_first", rq[0], 32'h03020100);
            chk("t5_w64", rq[64], exp_word(24'h00FF00, 64));
            chk("t5_last", rq[255], 32'hFFFEFDFC);
            chk("t5_span", 32'(rc[255] - rc[0]), 32'd2040);
        end

        chk("oe_errors", oe_bad, 32'd0);
        chk("sck_while_deselected", sck_hi, 32'd0);
        chk("csn_gap_ok", 32'(min_gap >= CSNH), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
